axil_default_slave_err: RTL and testbench
=========================================

// Module: axil_default_slave_err
// PURPOSE
//  Parametrised AXI-Lite default slave for the interconnect. Sinks read and write transactions whose
//  address matches no slave and answers each with a configurable error response. Handles the full AW/W
//  handshake in either order and adds a read channel, saturating error counters and last-bad-address capture.
// PARAMETERS
//  AXI_DATA_WIDTH   32            data bus width; must be 32 or 64
//  AXI_ADDR_WIDTH   32            address bus width
//  ERR_RESP         2'b11         bresp/rresp value for errors (2'b10 SLVERR, 2'b11 DECERR)
//  RD_DATA_PATTERN  'hDEADBEEF    rdata returned on error reads (AXI_DATA_WIDTH bits)
//  CNT_WIDTH        16            width of each error counter
// PORTS
//  aclk            in   1                  clock
//  aresetn         in   1                  reset, synchronous, active-low
//  slv_invalid_wr  in   1                  decoder: pending write targets no slave
//  slv_invalid_rd  in   1                  decoder: pending read targets no slave
//  s_axil_awaddr   in   AXI_ADDR_WIDTH     write address
//  s_axil_awvalid  in   1                  write address valid
//  s_axil_awready  out  1                  write address ready
//  s_axil_wdata    in   AXI_DATA_WIDTH     write data (discarded)
//  s_axil_wstrb    in   AXI_DATA_WIDTH/8   write strobes (discarded)
//  s_axil_wvalid   in   1                  write data valid
//  s_axil_wready   out  1                  write data ready
//  s_axil_bresp    out  2                  write response
//  s_axil_bvalid   out  1                  write response valid
//  s_axil_bready   in   1                  write response ready
//  s_axil_araddr   in   AXI_ADDR_WIDTH     read address
//  s_axil_arvalid  in   1                  read address valid
//  s_axil_arready  out  1                  read address ready
//  s_axil_rdata    out  AXI_DATA_WIDTH     read data
//  s_axil_rresp    out  2                  read response
//  s_axil_rvalid   out  1                  read data valid
//  s_axil_rready   in   1                  read data ready
//  cnt_clr         in   1                  synchronous clear of both counters
//  err_wr_cnt      out  CNT_WIDTH          completed error writes (saturating)
//  err_rd_cnt      out  CNT_WIDTH          completed error reads (saturating)
//  err_last_addr   out  AXI_ADDR_WIDTH     address of the most recent error transaction
//  err_last_is_wr  out  1                  1 = err_last_addr came from AW; 0 = from AR
// BEHAVIOUR
//  - Reset: every output 0. Both FSMs go to IDLE. Flags cleared. An in-flight transaction is abandoned, no response issued.
//  - All outputs are registered. Write and read FSMs run independently and concurrently.
//  - Write FSM W_IDLE/W_ACPT/W_RESP:
//    W_IDLE: slv_invalid_wr=1 at edge N -> W_ACPT; awready=wready=1 from N+1.
//    W_ACPT: awvalid&awready drops awready next cycle, sets aw_done, captures awaddr.
//      wvalid&wready drops wready next cycle, sets w_done. Either order or the same cycle.
//      When aw_done&w_done (including handshakes in the current cycle) -> W_RESP; bvalid=1, bresp=ERR_RESP next cycle.
//    W_RESP: bvalid/bresp held stable until bready. On bvalid&bready -> W_IDLE, bvalid=0, bresp=00, flags cleared.
//  - Read FSM R_IDLE/R_ACPT/R_RESP:
//    slv_invalid_rd=1 -> R_ACPT (arready=1 next cycle).
//    arvalid&arready -> R_RESP: rvalid=1, rresp=ERR_RESP, rdata=RD_DATA_PATTERN next cycle.
//    On rvalid&rready -> R_IDLE; rvalid=0, rdata=0, rresp=00.
//  - slv_invalid_* is ignored outside IDLE. Minimum turnaround is 1 idle cycle between transactions per channel.
//  - Counters: +1 on each bvalid&bready (wr) or rvalid&rready (rd); hold at all-ones.
//    cnt_clr wins over a same-cycle increment: result 0.
//  - err_last_addr/err_last_is_wr update on each AW or AR handshake. If both occur in the same cycle, AW wins (is_wr=1).
// TESTING
//  - invalid_wr, AW cyc 2, W cyc 5 -> bvalid=1, bresp=11 one cycle after W handshake; err_wr_cnt=1.
//  - W before AW, then AW+W same cycle -> one B per transaction; awready/wready never re-assert mid-transaction.
//  - bready low 6 cycles -> bvalid/bresp stable throughout; drops the cycle after bready=1.
//  - read to 0x4000_0010 -> rdata=DEADBEEF, rresp=11; err_last_addr=0x40000010, is_wr=0; ERR_RESP=10 build -> rresp=10.
//  - Concurrent write 0x100 and read 0x200, AW/AR same cycle -> both respond; err_last_addr=0x100, is_wr=1.
//  - CNT_WIDTH=2: 5 error reads -> err_rd_cnt=3. cnt_clr with a same-cycle B handshake -> err_wr_cnt=0. Reset in W_ACPT -> all outputs 0, no bvalid.

Source files
------------

// File: rtl/axil_default_slave_err.sv
// ============================================================================
//  Module  : axil_default_slave_err
//  Brief   : AXI-Lite default slave answering unmapped reads/writes with an
//            error response; keeps saturating error counters and last bad address.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_default_slave_err #(
    parameter int                        AXI_DATA_WIDTH  = 32,
    parameter int                        AXI_ADDR_WIDTH  = 32,
    parameter logic [1:0]                ERR_RESP        = 2'b11,
    parameter logic [AXI_DATA_WIDTH-1:0] RD_DATA_PATTERN = 'hDEADBEEF,
    parameter int                        CNT_WIDTH       = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        slv_invalid_wr,
    input  logic                        slv_invalid_rd,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic                        s_axil_awvalid,
    output logic                        s_axil_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                        s_axil_wvalid,
    output logic                        s_axil_wready,
    output logic [1:0]                  s_axil_bresp,
    output logic                        s_axil_bvalid,
    input  logic                        s_axil_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic                        s_axil_arvalid,
    output logic                        s_axil_arready,
    output logic [AXI_DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]                  s_axil_rresp,
    output logic                        s_axil_rvalid,
    input  logic                        s_axil_rready,
    input  logic                        cnt_clr,
    output logic [CNT_WIDTH-1:0]        err_wr_cnt,
    output logic [CNT_WIDTH-1:0]        err_rd_cnt,
    output logic [AXI_ADDR_WIDTH-1:0]   err_last_addr,
    output logic                        err_last_is_wr
);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_ACPT = 2'd1, W_RESP = 2'd2} wr_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ACPT = 2'd1, R_RESP = 2'd2} rd_state_t;

    wr_state_t                 wr_state_q, wr_state_d;
    rd_state_t                 rd_state_q, rd_state_d;
    logic                      awready_q, awready_d, wready_q, wready_d;
    logic                      bvalid_q, bvalid_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [1:0]                bresp_q, bresp_d, rresp_q, rresp_d;
    logic                      arready_q, arready_d, rvalid_q, rvalid_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CNT_WIDTH-1:0]      wr_cnt_q, rd_cnt_q;
    logic [AXI_ADDR_WIDTH-1:0] last_addr_q;
    logic                      last_is_wr_q;

    // Write payload is sunk without being looked at.
    logic w_unused;
    assign w_unused = ^{s_axil_wdata, s_axil_wstrb};

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    assign w_aw_hs = s_axil_awvalid & awready_q;
    assign w_w_hs  = s_axil_wvalid  & wready_q;
    assign w_b_hs  = bvalid_q & s_axil_bready;
    assign w_ar_hs = s_axil_arvalid & arready_q;
    assign w_r_hs  = rvalid_q & s_axil_rready;

    always_comb begin
        wr_state_d = wr_state_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        case (wr_state_q)
            W_IDLE: begin
                if (slv_invalid_wr) begin
                    wr_state_d = W_ACPT;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                end
            end
            W_ACPT: begin
                if (w_aw_hs) begin
                    awready_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_w_hs) begin
                    wready_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // Handshakes landing this cycle count towards completion.
                if ((aw_done_q | w_aw_hs) && (w_done_q | w_w_hs)) begin
                    wr_state_d = W_RESP;
                    bvalid_d   = 1'b1;
                    bresp_d    = ERR_RESP;
                end
            end
            W_RESP: begin
                if (w_b_hs) begin
                    wr_state_d = W_IDLE;
                    bvalid_d   = 1'b0;
                    bresp_d    = 2'b00;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            R_IDLE: begin
                if (slv_invalid_rd) begin
                    rd_state_d = R_ACPT;
                    arready_d  = 1'b1;
                end
            end
            R_ACPT: begin
                if (w_ar_hs) begin
                    rd_state_d = R_RESP;
                    arready_d  = 1'b0;
                    rvalid_d   = 1'b1;
                    rresp_d    = ERR_RESP;
                    rdata_d    = RD_DATA_PATTERN;
                end
            end
            R_RESP: begin
                if (w_r_hs) begin
                    rd_state_d = R_IDLE;
                    rvalid_d   = 1'b0;
                    rresp_d    = 2'b00;
                    rdata_d    = '0;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_state_q   <= W_IDLE;
            rd_state_q   <= R_IDLE;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= 2'b00;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rresp_q      <= 2'b00;
            rdata_q      <= '0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            last_addr_q  <= '0;
            last_is_wr_q <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            // Clear takes priority over a coincident completion.
            if (cnt_clr) begin
                wr_cnt_q <= '0;
                rd_cnt_q <= '0;
            end else begin
                if (w_b_hs && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + 1'b1;
                if (w_r_hs && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + 1'b1;
            end
            if (w_aw_hs) begin
                last_addr_q  <= s_axil_awaddr;
                last_is_wr_q <= 1'b1;
            end else if (w_ar_hs) begin
                last_addr_q  <= s_axil_araddr;
                last_is_wr_q <= 1'b0;
            end
        end
    end

    assign s_axil_awready = awready_q;
    assign s_axil_wready  = wready_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = arready_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rresp   = rresp_q;
    assign s_axil_rdata   = rdata_q;
    assign err_wr_cnt     = wr_cnt_q;
    assign err_rd_cnt     = rd_cnt_q;
    assign err_last_addr  = last_addr_q;
    assign err_last_is_wr = last_is_wr_q;

endmodule

`default_nettype wire

// File: tb/tb_axil_default_slave_err.sv
// ============================================================================
//  Module  : tb_axil_default_slave_err
//  Brief   : Directed bench; a second instance (SLVERR, 2-bit counters)
//            shares all inputs with the default build.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axil_default_slave_err;

    logic        aclk = 1'b0;
    logic        aresetn, inv_wr, inv_rd, awvalid, wvalid, bready, arvalid, rready, cnt_clr;
    logic [31:0] awaddr, araddr, wdata;
    logic [3:0]  wstrb;

    logic        awready, wready, bvalid, arready, rvalid, last_is_wr;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, last_addr;
    logic [15:0] wr_cnt, rd_cnt;

    logic        d2_awready, d2_wready, d2_bvalid, d2_arready, d2_rvalid, d2_last_is_wr;
    logic [1:0]  d2_bresp, d2_rresp, d2_wr_cnt, d2_rd_cnt;
    logic [31:0] d2_rdata, d2_last_addr;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    axil_default_slave_err dut (
        .aclk(aclk), .aresetn(aresetn), .slv_invalid_wr(inv_wr), .slv_invalid_rd(inv_rd),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .cnt_clr(cnt_clr), .err_wr_cnt(wr_cnt), .err_rd_cnt(rd_cnt),
        .err_last_addr(last_addr), .err_last_is_wr(last_is_wr)
    );

    axil_default_slave_err #(.ERR_RESP(2'b10), .CNT_WIDTH(2)) dut2 (
        .aclk(aclk), .aresetn(aresetn), .slv_invalid_wr(inv_wr), .slv_invalid_rd(inv_rd),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(d2_awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(d2_wready),
        .s_axil_bresp(d2_bresp), .s_axil_bvalid(d2_bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(d2_arready),
        .s_axil_rdata(d2_rdata), .s_axil_rresp(d2_rresp), .s_axil_rvalid(d2_rvalid), .s_axil_rready(rready),
        .cnt_clr(cnt_clr), .err_wr_cnt(d2_wr_cnt), .err_rd_cnt(d2_rd_cnt),
        .err_last_addr(d2_last_addr), .err_last_is_wr(d2_last_is_wr)
    );

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [31:0] addr);
        inv_rd = 1'b1; tick(); inv_rd = 1'b0;
        araddr = addr; arvalid = 1'b1; tick(); arvalid = 1'b0;
        rready = 1'b1; tick(); rready = 1'b0;
        tick();
    endtask

    initial begin
        aresetn = 1'b0; inv_wr = 1'b0; inv_rd = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b0; arvalid = 1'b0; rready = 1'b0; cnt_clr = 1'b0;
        awaddr = '0; araddr = '0; wdata = 32'h1234_5678; wstrb = 4'hF;
        tick(); tick(); tick();
        chk("rst_awready", awready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_wr_cnt", wr_cnt, 0);
        chk("rst_last_addr", last_addr, 0);
        aresetn = 1'b1; tick();

        // Write: AW two cycles after accept, W three cycles later
        inv_wr = 1'b1; tick(); inv_wr = 1'b0;
        chk("w1_awready_up", awready, 1);
        chk("w1_wready_up", wready, 1);
        awaddr = 32'h0000_0AA0; awvalid = 1'b1; tick(); awvalid = 1'b0;
        chk("w1_awready_drop", awready, 0);
        chk("w1_wready_hold", wready, 1);
        chk("w1_bvalid_early", bvalid, 0);
        chk("w1_last_addr", last_addr, 32'h0000_0AA0);
        chk("w1_is_wr", last_is_wr, 1);
        tick(); tick();
        wvalid = 1'b1; tick(); wvalid = 1'b0;
        chk("w1_bvalid", bvalid, 1);
        chk("w1_bresp", bresp, 2'b11);
        chk("w1_wready_drop", wready, 0);
        bready = 1'b1; tick(); bready = 1'b0;
        chk("w1_bvalid_drop", bvalid, 0);
        chk("w1_bresp_clr", bresp, 0);
        chk("w1_wr_cnt", wr_cnt, 1);
        tick();

        // Write: W before AW
        inv_wr = 1'b1; tick(); inv_wr = 1'b0;
        wvalid = 1'b1; tick(); wvalid = 1'b0;
        chk("w2_wready_drop", wready, 0);
        chk("w2_awready_hold", awready, 1);
        chk("w2_bvalid_early", bvalid, 0);
        tick();
        chk("w2_wready_stays", wready, 0);
        awaddr = 32'h0000_0BB0; awvalid = 1'b1; tick(); awvalid = 1'b0;
        chk("w2_bvalid", bvalid, 1);
        chk("w2_awready_drop", awready, 0);
        chk("w2_wready_low", wready, 0);
        bready = 1'b1; tick(); bready = 1'b0;
        chk("w2_wr_cnt", wr_cnt, 2);
        tick();

        // Write: AW and W together, then bready held low for 6 cycles
        inv_wr = 1'b1; tick(); inv_wr = 1'b0;
        awaddr = 32'h0000_0CC0; awvalid = 1'b1; wvalid = 1'b1; tick(); awvalid = 1'b0; wvalid = 1'b0;
        chk("w3_bvalid", bvalid, 1);
        chk("w3_awready_drop", awready, 0);
        chk("w3_wready_drop", wready, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("w3_bvalid_stall", bvalid, 1);
            chk("w3_bresp_stall", bresp, 2'b11);
            chk("w3_ready_low", {awready, wready}, 0);
        end
        bready = 1'b1; tick(); bready = 1'b0;
        chk("w3_bvalid_drop", bvalid, 0);
        chk("w3_wr_cnt", wr_cnt, 3);
        tick();

        // Read to 0x4000_0010
        inv_rd = 1'b1; tick(); inv_rd = 1'b0;
        chk("r1_arready_up", arready, 1);
        araddr = 32'h4000_0010; arvalid = 1'b1; tick(); arvalid = 1'b0;
        chk("r1_arready_drop", arready, 0);
        chk("r1_rvalid", rvalid, 1);
        chk("r1_rdata", rdata, 32'hDEAD_BEEF);
        chk("r1_rresp", rresp, 2'b11);
        chk("r1_rresp_slverr", d2_rresp, 2'b10);
        chk("r1_last_addr", last_addr, 32'h4000_0010);
        chk("r1_is_wr", last_is_wr, 0);
        rready = 1'b1; tick(); rready = 1'b0;
        chk("r1_rvalid_drop", rvalid, 0);
        chk("r1_rdata_clr", rdata, 0);
        chk("r1_rresp_clr", rresp, 0);
        chk("r1_rd_cnt", rd_cnt, 1);
        tick();

        // Concurrent write 0x100 / read 0x200, AW and AR together
        inv_wr = 1'b1; inv_rd = 1'b1; tick(); inv_wr = 1'b0; inv_rd = 1'b0;
        awaddr = 32'h100; araddr = 32'h200;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("c_bvalid", bvalid, 1);
        chk("c_rvalid", rvalid, 1);
        chk("c_last_addr", last_addr, 32'h100);
        chk("c_is_wr", last_is_wr, 1);
        bready = 1'b1; rready = 1'b1; tick(); bready = 1'b0; rready = 1'b0;
        chk("c_wr_cnt", wr_cnt, 4);
        chk("c_rd_cnt", rd_cnt, 2);
        tick();

        // Saturation of the 2-bit read counter
        do_read(32'h300);
        chk("sat_rd_cnt3", d2_rd_cnt, 3);
        do_read(32'h304);
        do_read(32'h308);
        chk("sat_rd_cnt_hold", d2_rd_cnt, 3);
        chk("wide_rd_cnt", rd_cnt, 5);
        chk("sat_last_addr", last_addr, 32'h308);

        // cnt_clr together with a B handshake
        inv_wr = 1'b1; tick(); inv_wr = 1'b0;
        awvalid = 1'b1; wvalid = 1'b1; tick(); awvalid = 1'b0; wvalid = 1'b0;
        chk("clr_bvalid", bvalid, 1);
        bready = 1'b1; cnt_clr = 1'b1; tick(); bready = 1'b0; cnt_clr = 1'b0;
        chk("clr_wr_cnt", wr_cnt, 0);
        chk("clr_rd_cnt", rd_cnt, 0);
        chk("clr_d2_wr_cnt", d2_wr_cnt, 0);
        chk("clr_bvalid_drop", bvalid, 0);
        tick();

        // Reset while waiting in W_ACPT
        inv_wr = 1'b1; tick(); inv_wr = 1'b0;
        chk("ra_awready", awready, 1);
        awvalid = 1'b1; tick(); awvalid = 1'b0;
        aresetn = 1'b0; wvalid = 1'b1; tick(); wvalid = 1'b0;
        chk("ra_awready_rst", awready, 0);
        chk("ra_wready_rst", wready, 0);
        chk("ra_bvalid_rst", bvalid, 0);
        chk("ra_last_addr_rst", last_addr, 0);
        chk("ra_is_wr_rst", last_is_wr, 0);
        aresetn = 1'b1; tick(); tick();
        chk("ra_bvalid_after", bvalid, 0);
        chk("ra_awready_after", awready, 0);
        chk("ra_wr_cnt_after", wr_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
